// File: rtl/conv2_window_gen_3ch.sv
// Three-channel 5x5 sliding-window generator for the second conv layer.
// Each channel keeps 4 rows + 5 pixels in a shift register; taps are wired straight off it.
module conv2_window_gen_3ch #(
    parameter int WIDTH  = 12,
    parameter int HEIGHT = 12,
    parameter int DW     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [DW-1:0]    data_in1,
    input  logic [DW-1:0]    data_in2,
    input  logic [DW-1:0]    data_in3,
    output logic [25*DW-1:0] out_win1,
    output logic [25*DW-1:0] out_win2,
    output logic [25*DW-1:0] out_win3,
    output logic             valid_out,
    output logic             frame_done
);

    localparam int K     = 5;
    localparam int DEPTH = 4 * WIDTH + 5;
    localparam int CW    = $clog2(WIDTH);
    localparam int RW    = $clog2(HEIGHT);

    logic [DW-1:0] line1 [DEPTH];
    logic [DW-1:0] line2 [DEPTH];
    logic [DW-1:0] line3 [DEPTH];

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          row_last;
    logic          win_ok;

    assign col_last = (col == CW'(WIDTH - 1));
    assign row_last = (row == RW'(HEIGHT - 1));
    // The accepted pixel must be at least four rows and four columns in.
    assign win_ok   = (row >= RW'(4)) && (col >= CW'(4));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                line1[i] <= '0;
                line2[i] <= '0;
                line3[i] <= '0;
            end
        end else if (valid_in) begin
            line1[0] <= data_in1;
            line2[0] <= data_in2;
            line3[0] <= data_in3;
            for (int i = 1; i < DEPTH; i++) begin
                line1[i] <= line1[i-1];
                line2[i] <= line2[i-1];
                line3[i] <= line3[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Strobes drop on any edge that does not accept a qualifying pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= valid_in && win_ok;
            frame_done <= valid_in && win_ok && col_last && row_last;
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            assign out_win1[DW*(r*K+c) +: DW] = line1[(4-r)*WIDTH + (4-c)];
            assign out_win2[DW*(r*K+c) +: DW] = line2[(4-r)*WIDTH + (4-c)];
            assign out_win3[DW*(r*K+c) +: DW] = line3[(4-r)*WIDTH + (4-c)];
        end
    end

endmodule

// File: tb/tb_conv2_window_gen_3ch.sv
// Directed bench for conv2_window_gen_3ch: ramp, gapped, back-to-back,
// mid-frame reset and sign-extreme frames on a 12x12 map.
module tb_conv2_window_gen_3ch;

    localparam int W  = 12;
    localparam int H  = 12;
    localparam int DW = 12;
    localparam int VW = 25 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] data_in1, data_in2, data_in3;
    logic [VW-1:0] out_win1, out_win2, out_win3;
    logic          valid_out, frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    conv2_window_gen_3ch #(.WIDTH(W), .HEIGHT(H), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .data_in3   (data_in3),
        .out_win1   (out_win1),
        .out_win2   (out_win2),
        .out_win3   (out_win3),
        .valid_out  (valid_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel pattern: mode 0 is the ramp, mode 1 alternates the signed extremes.
    function automatic logic [DW-1:0] pix(input int ch, input int mode, input int r, input int c);
        int v;
        if (mode == 0) begin
            v = r * W + c;
            if (ch == 2) v = v + 256;
            if (ch == 3) v = -v;
        end else begin
            v = ((r + c) % 2 == 1) ? 2047 : -2048;
            if (ch == 2) v = ((r + c) % 2 == 1) ? -2048 : 2047;
        end
        return DW'(v);
    endfunction

    function automatic logic [VW-1:0] exp_win(input int ch, input int mode, input int r, input int c);
        logic [VW-1:0] e;
        e = '0;
        for (int k = 0; k < 25; k++)
            e[DW*k +: DW] = pix(ch, mode, r - 4 + k / 5, c - 4 + k % 5);
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
            @(posedge clk);
            #1;
            chk("idle_valid_out", VW'(valid_out), VW'(0));
            chk("idle_frame_done", VW'(frame_done), VW'(0));
        end
    endtask

    task automatic run_frame(input int mode, input int gaps, input int n_pix);
        int  cnt;
        int  p;
        int  ng;
        logic q;
        logic d;
        cnt = 0;
        p   = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (p < n_pix) begin
                    if (gaps != 0) begin
                        ng = $urandom_range(1, 3);
                        repeat (ng) begin
                            @(negedge clk);
                            valid_in = 1'b0;
                            @(posedge clk);
                            #1;
                            chk("gap_valid_out", VW'(valid_out), VW'(0));
                        end
                    end
                    @(negedge clk);
                    valid_in = 1'b1;
                    data_in1 = pix(1, mode, r, c);
                    data_in2 = pix(2, mode, r, c);
                    data_in3 = pix(3, mode, r, c);
                    @(posedge clk);
                    #1;
                    q = (r >= 4) && (c >= 4);
                    d = q && (r == H - 1) && (c == W - 1);
                    chk($sformatf("valid_out r%0d c%0d", r, c), VW'(valid_out), VW'(q));
                    chk($sformatf("frame_done r%0d c%0d", r, c), VW'(frame_done), VW'(d));
                    if (q) begin
                        cnt++;
                        chk($sformatf("win1 r%0d c%0d", r, c), out_win1, exp_win(1, mode, r, c));
                        chk($sformatf("win2 r%0d c%0d", r, c), out_win2, exp_win(2, mode, r, c));
                        chk($sformatf("win3 r%0d c%0d", r, c), out_win3, exp_win(3, mode, r, c));
                        if (mode == 0 && r == 4 && c == 4) begin
                            chk("first_w1_tap0", VW'(out_win1[11:0]), VW'(12'd0));
                            chk("first_w1_tap4", VW'(out_win1[59:48]), VW'(12'd4));
                            chk("first_w1_tap20", VW'(out_win1[251:240]), VW'(12'd48));
                            chk("first_w1_tap24", VW'(out_win1[299:288]), VW'(12'd52));
                            chk("first_w2_tap0", VW'(out_win2[11:0]), VW'(12'd256));
                            chk("first_w3_tap24", VW'(out_win3[299:288]), VW'(12'hFCC));
                        end
                        if (mode == 0 && d) begin
                            chk("last_w1_tap24", VW'(out_win1[299:288]), VW'(12'd143));
                            chk("last_w1_tap0", VW'(out_win1[11:0]), VW'(12'd91));
                        end
                        if (mode == 1 && r == 4 && c == 4) begin
                            chk("ext_w1_tap24", VW'(out_win1[299:288]), VW'(12'h800));
                            chk("ext_w2_tap24", VW'(out_win2[299:288]), VW'(12'h7FF));
                            chk("ext_w3_tap23", VW'(out_win3[287:276]), VW'(12'h7FF));
                        end
                    end
                    p++;
                end
            end
        end
        if (n_pix == W * H)
            chk("window_count", VW'(cnt), VW'(64));
    endtask

    initial begin
        rst      = 1'b0;
        valid_in = 1'b0;
        data_in1 = '0;
        data_in2 = '0;
        data_in3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", VW'(valid_out), VW'(0));
        chk("rst_frame_done", VW'(frame_done), VW'(0));
        chk("rst_win1", out_win1, VW'(0));
        chk("rst_win2", out_win2, VW'(0));
        chk("rst_win3", out_win3, VW'(0));
        @(negedge clk);
        rst = 1'b1;

        // Ramp frame, window count and order.
        run_frame(0, 0, W * H);
        idle(3);

        // Same frame with random valid_in gaps.
        run_frame(0, 1, W * H);
        idle(2);

        // Two frames back to back.
        run_frame(0, 0, W * H);
        run_frame(0, 0, W * H);

        // Reset between edges after pixel 70, while a window strobe is high.
        run_frame(0, 0, 70);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid_out", VW'(valid_out), VW'(0));
        chk("midrst_frame_done", VW'(frame_done), VW'(0));
        chk("midrst_win1", out_win1, VW'(0));
        chk("midrst_win2", out_win2, VW'(0));
        chk("midrst_win3", out_win3, VW'(0));
        @(negedge clk);
        valid_in = 1'b0;
        rst      = 1'b1;
        run_frame(0, 0, W * H);
        idle(2);

        // Signed extremes pass through unchanged.
        run_frame(1, 0, W * H);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
